fix_field_arbiter: RTL and testbench

- Shares one downstream field bus between NUM_LANES parser lanes. Each lane is a fix_parser_out_module instance feeding first-word-fall-through tag/value FIFOs.
- Grants whole FIX messages, from the tag-8 field (sof) through the tag-10 field (eob), in round-robin order, so fields from different messages never interleave.
- Drops orphan fields, aborts runaway or truncated messages, and presents tag/value pairs on a valid/ready output register.

---
 rtl/fix_parser_pkg.sv | 22 ++
 rtl/fix_rr_arbiter.sv | 31 +++
 rtl/fix_field_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fix_field_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_parser_pkg.sv
// Shared constants and types for the FIX parser lanes and the field arbiter.
package fix_parser_pkg;

    localparam int FIX_TAG_W = 32;
    localparam int FIX_VAL_W = 256;

    localparam logic [7:0]  FIX_TAG_BEGIN    = 8'h38;    // ASCII "8"
    localparam logic [15:0] FIX_TAG_CHECKSUM = 16'h3130; // ASCII "10"

    typedef enum logic {
        IDLE,
        STREAM
    } arb_state_e;

    typedef struct packed {
        logic [FIX_TAG_W-1:0] tag;
        logic [FIX_VAL_W-1:0] value;
        logic                 sof;
        logic                 eob;
    } fix_field_t;

endpackage

// File: rtl/fix_rr_arbiter.sv
// Combinational round-robin pick: searches ptr_i, ptr_i+1, ... with wrap and
// returns the first requesting lane as one-hot grant and index.
module fix_rr_arbiter #(
    parameter  int NUM_LANES = 4,
    localparam int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_LANES-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int ofs);
        return IDX_W'((int'(base) + ofs) % NUM_LANES);
    endfunction

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!any_o && req_i[wrap_add(ptr_i, i)]) begin
                any_o                      = 1'b1;
                idx_o                      = wrap_add(ptr_i, i);
                gnt_o[wrap_add(ptr_i, i)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fix_field_arbiter.sv
// Grants whole FIX messages (sof..eob) from NUM_LANES lanes onto one valid/ready
// field bus. Define FIX_ARB_STATS_EN to add msg_count_o / drop_count_o.
module fix_field_arbiter
    import fix_parser_pkg::*;
#(
    parameter  int NUM_LANES  = 4,
    parameter  int TAG_W      = FIX_TAG_W,
    parameter  int VAL_W      = FIX_VAL_W,
    parameter  int MAX_FIELDS = 64,
    localparam int IDX_W      = $clog2(NUM_LANES),
    localparam int CNT_W      = $clog2(MAX_FIELDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       lane_empty_i,
    output logic [NUM_LANES-1:0]       lane_rd_en_o,
    input  logic [NUM_LANES*TAG_W-1:0] lane_tag_i,
    input  logic [NUM_LANES*VAL_W-1:0] lane_value_i,
    input  logic [NUM_LANES-1:0]       lane_sof_i,
    input  logic [NUM_LANES-1:0]       lane_eob_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [TAG_W-1:0]           out_tag_o,
    output logic [VAL_W-1:0]           out_value_o,
    output logic [IDX_W-1:0]           out_lane_o,
    output logic                       out_sof_o,
    output logic                       out_eob_o,
    output logic                       abort_o
`ifdef FIX_ARB_STATS_EN
    ,
    output logic [15:0]                msg_count_o,
    output logic [15:0]                drop_count_o
`endif
);

    arb_state_e           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt, r_gnt, w_gnt_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     w_pick, w_src;
    logic [NUM_LANES-1:0] w_pick_oh, w_gnt_oh;
    logic                 w_any, w_free, w_pop, w_load, w_orphan, w_abort_nxt;
    logic                 w_head_vld, w_head_sof, w_head_eob;
    logic                 r_valid, r_sof, r_eob, r_abort;
    logic [TAG_W-1:0]     r_tag;
    logic [VAL_W-1:0]     r_value;
    logic [IDX_W-1:0]     r_lane;

    fix_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_rr (
        .req_i (~lane_empty_i),
        .ptr_i (r_ptr),
        .gnt_o (w_pick_oh),
        .idx_o (w_pick),
        .any_o (w_any)
    );

    // In IDLE the head comes from the round-robin pick, in STREAM from the granted lane.
    assign w_src      = (r_state == IDLE) ? w_pick : r_gnt;
    assign w_gnt_oh   = NUM_LANES'(1) << r_gnt;
    assign w_head_vld = (r_state == IDLE) ? w_any : !lane_empty_i[r_gnt];
    assign w_head_sof = lane_sof_i[w_src];
    assign w_head_eob = lane_eob_i[w_src];
    assign w_free     = !r_valid || out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_orphan    = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_head_vld && !w_head_sof) begin
                    w_pop    = 1'b1;
                    w_orphan = 1'b1;
                end else if (w_head_vld && w_free) begin
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_gnt_nxt = w_pick;
                    w_ptr_nxt = (w_pick == IDX_W'(NUM_LANES - 1)) ? '0 : w_pick + IDX_W'(1);
                    w_cnt_nxt = CNT_W'(1);
                end
            end
            STREAM: begin
                if (w_head_vld && w_head_sof) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_head_vld && w_free) begin
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A loaded field decides where the message goes next; hitting the field cap aborts it.
        if (w_load) begin
            if (w_head_eob) begin
                w_state_nxt = IDLE;
            end else if (w_cnt_nxt == CNT_W'(MAX_FIELDS)) begin
                w_abort_nxt = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = STREAM;
            end
        end
    end

    always_comb begin
        lane_rd_en_o = '0;
        if (w_pop && !rst)
            lane_rd_en_o = (r_state == IDLE) ? w_pick_oh : w_gnt_oh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // Output register: reloads only when free, so a stalled field holds stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_value <= '0;
            r_lane  <= '0;
            r_sof   <= 1'b0;
            r_eob   <= 1'b0;
        end else if (w_free) begin
            r_valid <= w_load;
            if (w_load) begin
                r_tag   <= lane_tag_i[w_src*TAG_W +: TAG_W];
                r_value <= lane_value_i[w_src*VAL_W +: VAL_W];
                r_lane  <= w_src;
                r_sof   <= (r_state == IDLE);
                r_eob   <= w_head_eob;
            end
        end
    end

    assign out_valid_o = r_valid;
    assign out_tag_o   = r_tag;
    assign out_value_o = r_value;
    assign out_lane_o  = r_lane;
    assign out_sof_o   = r_sof;
    assign out_eob_o   = r_eob;
    assign abort_o     = r_abort;

`ifdef FIX_ARB_STATS_EN
    logic [15:0] r_msg_cnt, r_drop_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_msg_cnt  <= sat_inc(r_msg_cnt, r_valid && out_ready_i && r_eob);
            r_drop_cnt <= sat_inc(r_drop_cnt, w_orphan || w_abort_nxt);
        end
    end

    assign msg_count_o  = r_msg_cnt;
    assign drop_count_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fix_field_arbiter.sv
// Directed bench for fix_field_arbiter: per-lane FWFT FIFO models, a vector
// table for the streaming cases and hand-written multi-cycle corner sequences.
module tb_fix_field_arbiter;

    localparam int NL = 4;
    localparam int TW = 32;
    localparam int VW = 32;
    localparam int MF = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NL-1:0]     lane_empty_i = '1;
    logic [NL-1:0]     lane_rd_en_o;
    logic [NL*TW-1:0]  lane_tag_i = '0;
    logic [NL*VW-1:0]  lane_value_i = '0;
    logic [NL-1:0]     lane_sof_i = '0;
    logic [NL-1:0]     lane_eob_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [TW-1:0]     out_tag_o;
    logic [VW-1:0]     out_value_o;
    logic [1:0]        out_lane_o;
    logic              out_sof_o;
    logic              out_eob_o;
    logic              abort_o;
`ifdef FIX_ARB_STATS_EN
    logic [15:0]       msg_count_o;
    logic [15:0]       drop_count_o;
`endif

    fix_field_arbiter #(
        .NUM_LANES (NL),
        .TAG_W     (TW),
        .VAL_W     (VW),
        .MAX_FIELDS(MF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lane_empty_i (lane_empty_i),
        .lane_rd_en_o (lane_rd_en_o),
        .lane_tag_i   (lane_tag_i),
        .lane_value_i (lane_value_i),
        .lane_sof_i   (lane_sof_i),
        .lane_eob_i   (lane_eob_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_tag_o    (out_tag_o),
        .out_value_o  (out_value_o),
        .out_lane_o   (out_lane_o),
        .out_sof_o    (out_sof_o),
        .out_eob_o    (out_eob_o),
        .abort_o      (abort_o)
`ifdef FIX_ARB_STATS_EN
        ,
        .msg_count_o  (msg_count_o),
        .drop_count_o (drop_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [VW-1:0] val;
        logic          sof;
        logic          eob;
    } fld_t;

    typedef struct {
        logic          vld;
        logic [1:0]    lane;
        logic          sof;
        logic          eob;
        logic [TW-1:0] tag;
        logic [VW-1:0] val;
    } vec_t;

    fld_t          lq[NL][$];
    vec_t          tbl[11];
    logic [TW-1:0] etag[4];
    logic [NL-1:0] rd_acc;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [69:0] cur_out();
        return {abort_o, out_valid_o, out_lane_o, out_sof_o, out_eob_o, out_tag_o, out_value_o};
    endfunction

    function automatic logic [69:0] vexp(input vec_t v);
        return {1'b0, v.vld, v.lane, v.sof, v.eob, v.tag, v.val};
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < NL; k++) begin
            if (lq[k].size() > 0) begin
                lane_empty_i[k]          = 1'b0;
                lane_tag_i[k*TW +: TW]   = lq[k][0].tag;
                lane_value_i[k*VW +: VW] = lq[k][0].val;
                lane_sof_i[k]            = lq[k][0].sof;
                lane_eob_i[k]            = lq[k][0].eob;
            end else begin
                lane_empty_i[k]          = 1'b1;
                lane_tag_i[k*TW +: TW]   = '0;
                lane_value_i[k*VW +: VW] = '0;
                lane_sof_i[k]            = 1'b0;
                lane_eob_i[k]            = 1'b0;
            end
        end
    endtask

    task automatic push(input int ln, input logic [TW-1:0] tag, input logic [VW-1:0] val,
                        input logic sof, input logic eob);
        fld_t f;
        f.tag = tag; f.val = val; f.sof = sof; f.eob = eob;
        lq[ln].push_back(f);
        refresh();
    endtask

    // One clock: sample pops mid-cycle, then apply them to the FIFO models after the edge.
    task automatic tick();
        logic [NL-1:0] rd;
        fld_t          d;
        @(negedge clk);
        rd     = lane_rd_en_o;
        rd_acc = rd_acc | rd;
        chk("rd_onehot", 70'($countones(rd) <= 1), 70'(1));
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            if (rd[k]) begin
                chk("pop_nonempty", 70'(lq[k].size() != 0), 70'(1));
                if (lq[k].size() != 0) d = lq[k].pop_front();
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'd8,  32'hA1};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 32'd35, 32'hA2};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 1'b1, 32'd10, 32'hA3};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'd8,  32'h01};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, 32'd10, 32'h02};
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 1'b0, 32'd8,  32'h11};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 1'b1, 32'd10, 32'h12};
        tbl[7]  = '{1'b1, 2'd2, 1'b1, 1'b0, 32'd8,  32'h21};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'd10, 32'h22};
        tbl[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'd8,  32'h03};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b1, 32'd10, 32'h04};
        etag[0] = 32'd8; etag[1] = 32'd35; etag[2] = 32'd36; etag[3] = 32'd37;
        rd_acc  = '0;
        refresh();

        // Reset state
        tick();
        tick();
        chk("reset_out", cur_out(), 70'(0));
        chk("reset_rd", 70'(lane_rd_en_o), 70'(0));
        rst = 1'b0;

        // Single message on lane 0
        push(0, 32'd8, 32'hA1, 1'b1, 1'b0);
        push(0, 32'd35, 32'hA2, 1'b0, 1'b0);
        push(0, 32'd10, 32'hA3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("vec%0d", i), cur_out(), vexp(tbl[i]));
        end
        tick();
        chk("A_idle", 70'(out_valid_o), 70'(0));
`ifdef FIX_ARB_STATS_EN
        chk("A_msgcnt", 70'(msg_count_o), 70'(1));
`endif

        // Three lanes contending, lane 0 holds a second message
        do_reset();
        push(0, 32'd8, 32'h01, 1'b1, 1'b0);
        push(0, 32'd10, 32'h02, 1'b0, 1'b1);
        push(0, 32'd8, 32'h03, 1'b1, 1'b0);
        push(0, 32'd10, 32'h04, 1'b0, 1'b1);
        push(1, 32'd8, 32'h11, 1'b1, 1'b0);
        push(1, 32'd10, 32'h12, 1'b0, 1'b1);
        push(2, 32'd8, 32'h21, 1'b1, 1'b0);
        push(2, 32'd10, 32'h22, 1'b0, 1'b1);
        for (int i = 3; i < 11; i++) begin
            tick();
            chk($sformatf("vec%0d", i), cur_out(), vexp(tbl[i]));
        end
        tick();
        chk("B_idle", 70'(out_valid_o), 70'(0));

        // Backpressure mid-message; 4-field message ending exactly at the cap
        do_reset();
        push(2, 32'd8, 32'hC1, 1'b1, 1'b0);
        push(2, 32'd35, 32'hC2, 1'b0, 1'b0);
        push(2, 32'd49, 32'hC3, 1'b0, 1'b0);
        push(2, 32'd10, 32'hC4, 1'b0, 1'b1);
        tick();
        tick();
        chk("C_pre", 70'(out_tag_o), 70'(35));
        out_ready_i = 1'b0;
        rd_acc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("C_hold%0d", i), cur_out(), {1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'd35, 32'hC2});
        end
        chk("C_no_pop", 70'(rd_acc), 70'(0));
        out_ready_i = 1'b1;
        tick();
        chk("C_resume1", cur_out(), {1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'd49, 32'hC3});
        tick();
        chk("C_resume2", cur_out(), {1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 32'd10, 32'hC4});
        tick();
        chk("C_idle", 70'({out_valid_o, abort_o}), 70'(0));

        // Orphan field
        do_reset();
        push(1, 32'd35, 32'hD1, 1'b0, 1'b0);
        rd_acc = '0;
        tick();
        chk("D_pop", 70'(rd_acc), 70'(4'b0010));
        chk("D_noout", 70'(out_valid_o), 70'(0));
        chk("D_qempty", 70'(lq[1].size()), 70'(0));
`ifdef FIX_ARB_STATS_EN
        chk("D_drop", 70'(drop_count_o), 70'(1));
`endif

        // Runaway message: cap of 4 fields, then two orphans
        do_reset();
        push(0, 32'd8, 32'hE1, 1'b1, 1'b0);
        push(0, 32'd35, 32'hE2, 1'b0, 1'b0);
        push(0, 32'd36, 32'hE3, 1'b0, 1'b0);
        push(0, 32'd37, 32'hE4, 1'b0, 1'b0);
        push(0, 32'd38, 32'hE5, 1'b0, 1'b0);
        push(0, 32'd39, 32'hE6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("E_tag%0d", i), 70'({out_valid_o, out_tag_o}), 70'({1'b1, etag[i]}));
        end
        chk("E_abort", 70'({abort_o, out_eob_o}), 70'(2'b10));
        tick();
        chk("E_abort_end", 70'({abort_o, out_valid_o}), 70'(0));
        tick();
        tick();
        chk("E_drained", 70'({out_valid_o, 32'(lq[0].size())}), 70'(0));
`ifdef FIX_ARB_STATS_EN
        chk("E_drop", 70'(drop_count_o), 70'(3));
`endif

        // Truncated message: sof seen while streaming
        do_reset();
        push(3, 32'd8, 32'hF1, 1'b1, 1'b0);
        push(3, 32'd35, 32'hF2, 1'b0, 1'b0);
        push(3, 32'd8, 32'hF3, 1'b1, 1'b0);
        push(3, 32'd10, 32'hF4, 1'b0, 1'b1);
        tick();
        tick();
        chk("F_pre", 70'(out_tag_o), 70'(35));
        tick();
        chk("F_abort", 70'({abort_o, out_valid_o, 32'(lq[3].size())}), 70'({1'b1, 1'b0, 32'd2}));
        tick();
        chk("F_rearb", cur_out(), {1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 32'd8, 32'hF3});
        tick();
        chk("F_eob", cur_out(), {1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 32'd10, 32'hF4});

        // Reset during field 2; FIFOs untouched, restart at lane 0
        do_reset();
        push(1, 32'd8, 32'h61, 1'b1, 1'b0);
        push(1, 32'd35, 32'h62, 1'b0, 1'b0);
        push(1, 32'd36, 32'h63, 1'b0, 1'b0);
        push(1, 32'd10, 32'h64, 1'b0, 1'b1);
        tick();
        tick();
        chk("G_pre", 70'(out_tag_o), 70'(35));
        rst = 1'b1;
        push(0, 32'd8, 32'h65, 1'b1, 1'b0);
        push(0, 32'd10, 32'h66, 1'b0, 1'b1);
        rd_acc = '0;
        tick();
        chk("G_rst_out", 70'(out_valid_o), 70'(0));
        chk("G_rst_fifo", 70'({rd_acc, 32'(lq[1].size())}), 70'({4'b0000, 32'd2}));
        rst = 1'b0;
        tick();
        chk("G_restart", cur_out(), {1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'd8, 32'h65});
        for (int i = 0; i < 4; i++) tick();
        chk("G_drained", 70'({out_valid_o, 32'(lq[0].size() + lq[1].size())}), 70'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
